// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared FSM state encodings and default sizing for the UART TX buffer.
// Revision : 1.0
// ============================================================================
package uart_pkg;

    localparam int DEFAULT_DEPTH = 16;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LAUNCH    = 3'd1;
    localparam logic [2:0] ST_WAIT_CLR  = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] ST_POP       = 3'd4;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock FIFO with full flush and keep-head flush.
// Revision : 1.0
// ============================================================================
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int W     = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  logic [W-1:0]  i_push_data,
    input  logic          i_pop,
    input  logic          i_flush_all,
    input  logic          i_flush_keep_head,
    output logic [W-1:0]  o_head,
    output logic [AW:0]   o_count,
    output logic          o_full,
    output logic          o_empty
);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic w_flush;
    logic w_push;
    logic w_pop;

    assign w_flush = i_flush_all || i_flush_keep_head;
    assign w_push  = i_push && !o_full && !w_flush;
    assign w_pop   = i_pop && !o_empty;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush_all) begin
            r_rd_ptr <= r_wr_ptr;
            r_count  <= '0;
        end else if (i_flush_keep_head) begin
            // Everything behind the head is dropped; the head may pop in the same cycle.
            r_wr_ptr <= o_empty ? r_rd_ptr : r_rd_ptr + AW'(1);
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
                r_count  <= '0;
            end else begin
                r_count  <= o_empty ? '0 : (AW+1)'(1);
            end
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - (AW+1)'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_buffer.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_buffer
// Brief    : Byte FIFO plus launch FSM feeding a UART TX controller one byte at a time.
// Revision : 1.0
// ============================================================================
module uart_tx_buffer
    import uart_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_wr_en,
    input  logic [7:0]    i_wr_data,
    input  logic          i_flush,
    input  logic          i_clr_ovf,
    input  logic          i_tx_done,
    output logic [7:0]    o_tx_data,
    output logic          o_tx_send,
    output logic          o_full,
    output logic          o_empty,
    output logic [AW:0]   o_count,
    output logic          o_busy,
    output logic          o_overflow
);

    logic [2:0] r_state;
    logic [2:0] w_next_state;
    logic [7:0] r_tx_data;
    logic       r_overflow;
    logic [7:0] w_head;
    logic       w_load;
    logic       w_send;
    logic       w_pop;
    logic       w_flush_all;
    logic       w_flush_keep;
    logic       w_ovf_set;

    assign w_flush_all  = i_flush && (r_state == ST_IDLE);
    assign w_flush_keep = i_flush && (r_state != ST_IDLE);
    assign w_ovf_set    = i_wr_en && o_full && !i_flush;

    sync_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (8)
    ) u_fifo (
        .i_clk             (i_clk),
        .i_rst             (i_rst),
        .i_push            (i_wr_en),
        .i_push_data       (i_wr_data),
        .i_pop             (w_pop),
        .i_flush_all       (w_flush_all),
        .i_flush_keep_head (w_flush_keep),
        .o_head            (w_head),
        .o_count           (o_count),
        .o_full            (o_full),
        .o_empty           (o_empty)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_tx_data  <= 8'h00;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_load) begin
                r_tx_data <= w_head;
            end
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (i_clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // TX's done flag is still high from the previous frame, so it must be seen low first.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:      if (!o_empty && !i_flush) w_next_state = ST_LAUNCH;
            ST_LAUNCH:    w_next_state = ST_WAIT_CLR;
            ST_WAIT_CLR:  if (!i_tx_done) w_next_state = ST_WAIT_DONE;
            ST_WAIT_DONE: if (i_tx_done) w_next_state = ST_POP;
            ST_POP:       w_next_state = ST_IDLE;
            default:      w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_load = 1'b0;
        w_send = 1'b0;
        w_pop  = 1'b0;
        case (r_state)
            ST_IDLE:   w_load = !o_empty && !i_flush;
            ST_LAUNCH: w_send = 1'b1;
            ST_POP:    w_pop  = 1'b1;
            default:   ;
        endcase
    end

    assign o_tx_data  = r_tx_data;
    assign o_tx_send  = w_send;
    assign o_busy     = (r_state != ST_IDLE);
    assign o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_buffer
// Brief    : Directed self-checking bench for uart_tx_buffer.
// Revision : 1.0
// ============================================================================
module tb_uart_tx_buffer;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       flush;
    logic       clr_ovf;
    logic       tx_done;
    logic [7:0] tx_data;
    logic       tx_send;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       busy;
    logic       overflow;

    int n_cmp = 0;
    int n_err = 0;

    uart_tx_buffer #(.DEPTH(16), .AW(4)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_wr_en    (wr_en),
        .i_wr_data  (wr_data),
        .i_flush    (flush),
        .i_clr_ovf  (clr_ovf),
        .i_tx_done  (tx_done),
        .o_tx_data  (tx_data),
        .o_tx_send  (tx_send),
        .o_full     (full),
        .o_empty    (empty),
        .o_count    (count),
        .o_busy     (busy),
        .o_overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Complete the frame in flight: done drops, stays low, rises; FSM pops and idles.
    task automatic finish_frame();
        tx_done = 1'b0;
        repeat (3) tick();
        tx_done = 1'b1;
        tick();
        tick();
    endtask

    task automatic tx_serve(input logic [7:0] exp_byte);
        int k;
        k = 0;
        while (!tx_send && k < 50) begin
            tick();
            k++;
        end
        chk("serve_send_seen", tx_send, 1);
        chk("serve_data", tx_data, exp_byte);
        finish_frame();
    endtask

    initial begin
        logic saw_send;
        rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; flush = 1'b0;
        clr_ovf = 1'b0; tx_done = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_busy", busy, 0);
        chk("rst_send", tx_send, 0);
        chk("rst_data", tx_data, 8'h00);
        chk("rst_ovf", overflow, 0);

        // Single byte: launch timing and two-phase done wait
        wr_en = 1'b1; wr_data = 8'hA5;
        tick();
        wr_en = 1'b0;
        chk("t1_count_after_wr", count, 1);
        chk("t1_send_n", tx_send, 0);
        tick();
        chk("t1_send_n1", tx_send, 1);
        chk("t1_data", tx_data, 8'hA5);
        chk("t1_busy", busy, 1);
        tick();
        chk("t1_send_n2", tx_send, 0);
        repeat (5) tick();
        chk("t4_hold_busy", busy, 1);
        chk("t4_hold_count", count, 1);
        chk("t4_hold_nosend", tx_send, 0);
        tx_done = 1'b0;
        repeat (100) tick();
        chk("t1_wait_count", count, 1);
        chk("t1_wait_data", tx_data, 8'hA5);
        tx_done = 1'b1;
        tick();
        chk("t1_pop_count", count, 1);
        tick();
        chk("t1_done_count", count, 0);
        chk("t1_done_empty", empty, 1);
        chk("t1_done_busy", busy, 0);

        // Fill to full with TX stalled, then overflow behaviour
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            tick();
        end
        wr_en = 1'b0;
        chk("t2_full", full, 1);
        chk("t2_count16", count, 16);
        chk("t2_head_data", tx_data, 8'h00);
        wr_en = 1'b1; wr_data = 8'hFF;
        tick();
        wr_en = 1'b0;
        chk("t2_ovf_set", overflow, 1);
        chk("t2_ovf_count", count, 16);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("t2_ovf_clr", overflow, 0);
        wr_en = 1'b1; clr_ovf = 1'b1;
        tick();
        wr_en = 1'b0; clr_ovf = 1'b0;
        chk("t2_ovf_set_wins", overflow, 1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("t2_ovf_clr2", overflow, 0);

        // Drain in order, then verify pointer wrap
        finish_frame();
        chk("t3_count15", count, 15);
        for (int i = 1; i < 16; i++) begin
            tx_serve(8'(i));
        end
        chk("t3_drain_count", count, 0);
        chk("t3_drain_empty", empty, 1);
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h10 + i);
            tick();
        end
        wr_en = 1'b0;
        chk("t3_wrap_head", tx_data, 8'h10);
        chk("t3_wrap_count", count, 4);
        finish_frame();
        for (int i = 1; i < 4; i++) begin
            tx_serve(8'(8'h10 + i));
        end
        chk("t3_wrap_empty", empty, 1);

        // Flush during WAIT_DONE keeps only the in-flight head
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h20 + i);
            tick();
        end
        wr_en = 1'b0;
        chk("t5_count5", count, 5);
        tx_done = 1'b0;
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t5_flush_count", count, 1);
        chk("t5_flush_busy", busy, 1);
        chk("t5_flush_data", tx_data, 8'h20);
        tx_done = 1'b1;
        tick();
        tick();
        chk("t5_end_count", count, 0);
        chk("t5_end_busy", busy, 0);
        saw_send = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (tx_send) saw_send = 1'b1;
        end
        chk("t5_no_send", saw_send, 0);

        // Reset mid-frame
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h30 + i);
            tick();
        end
        wr_en = 1'b0;
        tx_done = 1'b0;
        tick();
        tick();
        chk("t6_pre_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_count", count, 0);
        chk("t6_send", tx_send, 0);
        chk("t6_busy", busy, 0);
        chk("t6_data", tx_data, 8'h00);
        chk("t6_empty", empty, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_buffer.md
Name: uart_tx_buffer

Overview:
Byte FIFO plus launch controller sitting directly upstream of the UART TX controller. Accepts bytes from the MIPS memory-mapped UART write port at full clock rate and hands them one at a time to the TX controller. For each byte it holds the data stable, pulses send, and waits for the TX finish flag before popping. This decouples CPU stores from the serial baud rate.

Parameters:
DEPTH, 16, FIFO entries; power of two, at least 2
AW, 4, pointer width, log2(DEPTH)

Ports:
i_clk  in  1  system clock
i_rst  in  1  reset, synchronous, active-high
i_wr_en  in  1  write strobe from CPU bus
i_wr_data  in  8  byte to enqueue
i_flush  in  1  discard all queued bytes (synchronous)
i_clr_ovf  in  1  clear sticky overflow flag
i_tx_done  in  1  TX finish flag, level; cleared by TX on accept, set at end of frame
o_tx_data  out  8  byte presented to TX data register
o_tx_send  out  1  one-cycle send request to TX
o_full  out  1  count == DEPTH
o_empty  out  1  count == 0
o_count  out  AW+1  bytes queued, including the in-flight byte
o_busy  out  1  FSM not in IDLE
o_overflow  out  1  sticky; a write was dropped while full

Behaviour:
- Clock and reset: one clock; reset is synchronous, active-high (i_clk, i_rst).
- Reset values: pointers 0, count 0, o_tx_data 8'h00, o_tx_send 0, o_overflow 0, state IDLE, so o_empty=1, o_full=0, o_busy=0. Reset mid-frame aborts the byte without a pop; TX is not signalled.
- Write: when i_wr_en=1 and not full, store at wr_ptr and increment the pointer (mod DEPTH, natural wrap). When i_wr_en=1 and full, drop the byte, leave count unchanged, and set o_overflow.
- o_overflow is cleared by i_clr_ovf. A simultaneous set and clear resolves to set.
- Pop happens only in the POP state. A write and pop in the same cycle leave count unchanged. Count never exceeds DEPTH or goes below 0.
- The head entry stays in the FIFO until POP, so o_count includes the in-flight byte.
- FSM states:
  - IDLE: if count != 0, latch mem[rd_ptr] into o_tx_data and go to LAUNCH.
  - LAUNCH: o_tx_send=1 for this cycle only; go to WAIT_CLR.
  - WAIT_CLR: wait until i_tx_done=0 (TX has cleared its finish flag); go to WAIT_DONE.
  - WAIT_DONE: wait until i_tx_done=1; go to POP.
  - POP: increment rd_ptr and decrement count; go to IDLE.
- o_tx_data stays constant from LAUNCH through POP.
- Latency: a write at edge N into an empty, idle buffer gives LAUNCH (o_tx_send high) in cycle N+1 to N+2. Back-to-back bytes take 2 cycles of IDLE/POP overhead beyond the TX frame time.
- The 2-phase done wait is mandatory: i_tx_done is still high from the previous frame at LAUNCH, so it must be seen low before it is accepted as high.
- i_flush:
  - In IDLE: zero count and set rd_ptr=wr_ptr.
  - In any other state: discard every entry except the head, and let the in-flight byte finish normally and pop.
  - A write coincident with flush is dropped.
  - Flush has priority over write.
- o_busy = (state != IDLE).
- Illegal state encodings return to IDLE.

Decomposition:
- Shared package/include uart_pkg: state encodings (3-bit localparams), default DEPTH.
- One natural sub-module: sync_fifo (parameterised DEPTH/width 8, with push/pop/flush/count). The FSM and overflow logic stay in uart_tx_buffer.

Test Plan:
1. Reset, then write 8'hA5 at edge N -> o_tx_send=1 only in cycle N+1; o_tx_data=8'hA5; o_count=1 until done; TX model drops done, raises it 100 cycles later -> POP, o_count=0, o_empty=1.
2. Write 16 bytes 8'h00..8'h0F back-to-back with TX stalled -> o_full=1 after the 16th write. A 17th write of 8'hFF -> dropped, o_overflow=1, count=16. i_clr_ovf -> o_overflow=0.
3. Drain (2) with the TX model -> 16 send pulses carrying 8'h00..8'h0F in order; pointer wrap verified by writing 4 more bytes afterwards, which arrive as 8'h10..8'h13.
4. With i_tx_done stuck high from a prior frame and a new byte launched -> FSM holds in WAIT_CLR, no pop, until done drops and rises again.
5. Queue 5 bytes, assert i_flush during WAIT_DONE -> head byte completes and pops, count ends at 0, no further o_tx_send.
6. Assert i_rst during WAIT_DONE with 3 bytes queued -> next cycle count=0, o_tx_send=0, o_busy=0, o_tx_data=8'h00.
